// File: rtl/sru_seq_ctrl.sv
// rtl/sru_seq_ctrl.sv - phase sequencer for the softmax result unit
//
// Converts one start pulse into the ordered SRU strobe sequence:
//   REC   : soft_rec for NUM_PASS passes of REC_CYCLES, total_counter = pass
//   FAC   : one idle gap cycle, then find_fac for FAC_CYCLES cycles
//   DWAIT : strobes low until deno_ready
//   RES   : soft_fac for RES_CYCLES+1 cycles (prime cycle, then res_valid beats)
//   DONE  : one-cycle done pulse
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               run request, honoured only in IDLE
//   abort               synchronous cancel, wins over every transition
//   deno_ready          denominator buffer filled (level)
//   soft_rec/find_fac/soft_fac   SRU phase strobes (mutually exclusive)
//   total_counter[7:0]  current capture pass, zero-extended
//   res_valid           SRU result beat valid
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle completion pulse
//
// Optional build macro SRU_SEQ_CTRL_PERF_EN adds:
//   perf_cycles[31:0]   cycles of the last/current run, start..done inclusive
//   perf_stall[31:0]    cycles spent waiting for deno_ready
module sru_seq_ctrl #(
  parameter int REC_CYCLES = 64,
  parameter int NUM_PASS   = 4,
  parameter int FAC_CYCLES = 69,
  parameter int RES_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       deno_ready,
  output logic       soft_rec,
  output logic       find_fac,
  output logic       soft_fac,
  output logic [7:0] total_counter,
  output logic       res_valid,
  output logic       busy,
  output logic       done
`ifdef SRU_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);

  // FAC's counter also spans the leading gap cycle, so it needs FAC_CYCLES+1 values.
  localparam int CNT_N_A = (REC_CYCLES > FAC_CYCLES + 1) ? REC_CYCLES : FAC_CYCLES + 1;
  localparam int CNT_N   = (CNT_N_A > RES_CYCLES + 1) ? CNT_N_A : RES_CYCLES + 1;
  localparam int CNT_W   = $clog2(CNT_N);
  localparam int PASS_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

  localparam logic [CNT_W-1:0]  REC_LAST  = CNT_W'(REC_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FAC_LAST  = CNT_W'(FAC_CYCLES);
  localparam logic [CNT_W-1:0]  RES_LAST  = CNT_W'(RES_CYCLES);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_FAC,
    S_DWAIT,
    S_RES,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PASS_W-1:0]  pass;

  assign busy = (state != S_IDLE);

  // Outputs are registered alongside the state: each transition loads the
  // strobe values that belong to the cycle being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pass          <= '0;
      soft_rec      <= 1'b0;
      find_fac      <= 1'b0;
      soft_fac      <= 1'b0;
      res_valid     <= 1'b0;
      done          <= 1'b0;
      total_counter <= '0;
    end else if (abort && state != S_IDLE) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pass          <= '0;
      soft_rec      <= 1'b0;
      find_fac      <= 1'b0;
      soft_fac      <= 1'b0;
      res_valid     <= 1'b0;
      done          <= 1'b0;
      total_counter <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state         <= S_REC;
            cnt           <= '0;
            pass          <= '0;
            soft_rec      <= 1'b1;
            total_counter <= '0;
          end
        end

        S_REC: begin
          if (cnt == REC_LAST) begin
            cnt <= '0;
            if (pass == PASS_LAST) begin
              // First FAC cycle is the gap: both soft_rec and find_fac low.
              state    <= S_FAC;
              soft_rec <= 1'b0;
            end else begin
              pass          <= pass + 1'b1;
              total_counter <= 8'(pass) + 8'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FAC: begin
          if (cnt == FAC_LAST) begin
            state    <= S_DWAIT;
            find_fac <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            find_fac <= 1'b1;
          end
        end

        S_DWAIT: begin
          if (deno_ready) begin
            state    <= S_RES;
            soft_fac <= 1'b1;
            cnt      <= '0;
          end
        end

        S_RES: begin
          // cnt==0 is the prime cycle; res_valid follows on cnt 1..RES_CYCLES.
          if (cnt == RES_LAST) begin
            state     <= S_DONE;
            soft_fac  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            res_valid <= 1'b1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          done          <= 1'b0;
          pass          <= '0;
          total_counter <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRU_SEQ_CTRL_PERF_EN
  // The accepting cycle counts as the first cycle of the run, so after done
  // perf_cycles equals the start->done latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE) begin
      if (start && !abort) begin
        perf_cycles <= 32'd1;
        perf_stall  <= '0;
      end
    end else if (!abort) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (state == S_DWAIT) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

  strobe_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({soft_rec, find_fac, soft_fac}));

endmodule
